// File: rtl/c4_win_scanner_if.sv
// Handshake and result bundle between the board store, the controller and the win scanner.
// The controller (master) drives start/board; the scanner (slave) returns status and result.
interface c4_win_scanner_if;
  logic                   start;
  logic [0:5][0:6][1:0]   board;
  logic                   busy;
  logic                   done;
  logic [1:0]             winner;
  logic                   draw;
  logic [2:0]             win_row;
  logic [2:0]             win_col;
  logic [1:0]             win_dir;

  modport master (
    output start, board,
    input  busy, done, winner, draw, win_row, win_col, win_dir
  );

  modport slave (
    input  start, board,
    output busy, done, winner, draw, win_row, win_col, win_dir
  );
endinterface

// File: rtl/c4_win_scanner.sv
// Connect 4 end-of-game detector: snapshots the 6x7 board on start, scans one anchor
// per cycle in row-major order and reports the first win, a draw, or no result.
module c4_win_scanner (
  input  logic              clk,
  input  logic              rst,
  c4_win_scanner_if.slave   bus
);
  localparam int unsigned ROWS     = 6;
  localparam int unsigned COLS     = 7;
  localparam int unsigned CELLS    = ROWS * COLS;
  localparam int unsigned LAST_IDX = CELLS - 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [0:5][0:6][1:0]  r_snap, w_snap_nxt;
  logic [5:0]            r_idx, w_idx_nxt;
  logic [2:0]            r_row, w_row_nxt;
  logic [2:0]            r_col, w_col_nxt;
  logic                  r_busy, r_done;
  logic [1:0]            r_winner, w_winner_nxt;
  logic                  r_draw, w_draw_nxt;
  logic [2:0]            r_win_row, w_win_row_nxt;
  logic [2:0]            r_win_col, w_win_col_nxt;
  logic [1:0]            r_win_dir, w_win_dir_nxt;

  logic [CELLS-1:0]      w_h, w_v, w_dr, w_dl;
  logic [COLS-1:0]       w_row0_occ;
  logic                  w_hit;
  logic [1:0]            w_dir;
  logic [1:0]            w_anchor;

  // Per-anchor line matches; out-of-board directions are tied off at elaboration.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      localparam int unsigned IDX = gr * COLS + gc;
      logic [1:0] w_a;
      logic       w_occ;
      assign w_a   = r_snap[gr][gc];
      assign w_occ = ^w_a;

      if (gc <= 3) begin : g_h
        assign w_h[IDX] = w_occ && (r_snap[gr][gc+1] == w_a) &&
                          (r_snap[gr][gc+2] == w_a) && (r_snap[gr][gc+3] == w_a);
      end else begin : g_no_h
        assign w_h[IDX] = 1'b0;
      end

      if (gr <= 2) begin : g_v
        assign w_v[IDX] = w_occ && (r_snap[gr+1][gc] == w_a) &&
                          (r_snap[gr+2][gc] == w_a) && (r_snap[gr+3][gc] == w_a);
      end else begin : g_no_v
        assign w_v[IDX] = 1'b0;
      end

      if (gr <= 2 && gc <= 3) begin : g_dr
        assign w_dr[IDX] = w_occ && (r_snap[gr+1][gc+1] == w_a) &&
                           (r_snap[gr+2][gc+2] == w_a) && (r_snap[gr+3][gc+3] == w_a);
      end else begin : g_no_dr
        assign w_dr[IDX] = 1'b0;
      end

      if (gr <= 2 && gc >= 3) begin : g_dl
        assign w_dl[IDX] = w_occ && (r_snap[gr+1][gc-1] == w_a) &&
                           (r_snap[gr+2][gc-2] == w_a) && (r_snap[gr+3][gc-3] == w_a);
      end else begin : g_no_dl
        assign w_dl[IDX] = 1'b0;
      end
    end
  end

  // Encoding 11 counts as empty, so only 01/10 (odd parity) is an occupied cell.
  for (genvar gc = 0; gc < COLS; gc++) begin : g_top
    assign w_row0_occ[gc] = ^r_snap[0][gc];
  end

  assign w_anchor = r_snap[r_row][r_col];
  assign w_hit    = w_h[r_idx] | w_v[r_idx] | w_dr[r_idx] | w_dl[r_idx];

  // Direction priority H > V > DR > DL.
  always_comb begin
    w_dir = 2'b11;
    if (w_h[r_idx])       w_dir = 2'b00;
    else if (w_v[r_idx])  w_dir = 2'b01;
    else if (w_dr[r_idx]) w_dir = 2'b10;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_snap_nxt    = r_snap;
    w_idx_nxt     = r_idx;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_winner_nxt  = r_winner;
    w_draw_nxt    = r_draw;
    w_win_row_nxt = r_win_row;
    w_win_col_nxt = r_win_col;
    w_win_dir_nxt = r_win_dir;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_snap_nxt    = bus.board;
          w_idx_nxt     = '0;
          w_row_nxt     = '0;
          w_col_nxt     = '0;
          w_winner_nxt  = '0;
          w_draw_nxt    = 1'b0;
          w_win_row_nxt = '0;
          w_win_col_nxt = '0;
          w_win_dir_nxt = '0;
          w_state_nxt   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          w_winner_nxt  = w_anchor;
          w_win_row_nxt = r_row;
          w_win_col_nxt = r_col;
          w_win_dir_nxt = w_dir;
          w_state_nxt   = S_DONE;
        end else if (r_idx == 6'(LAST_IDX)) begin
          w_draw_nxt   = &w_row0_occ;
          w_winner_nxt = 2'b00;
          w_state_nxt  = S_DONE;
        end else begin
          w_idx_nxt = r_idx + 6'd1;
          if (r_col == 3'(COLS - 1)) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + 3'd1;
          end else begin
            w_col_nxt = r_col + 3'd1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_snap    <= '0;
      r_idx     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_winner  <= '0;
      r_draw    <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
      r_win_dir <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_snap    <= w_snap_nxt;
      r_idx     <= w_idx_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_busy    <= (w_state_nxt == S_SCAN);
      r_done    <= (w_state_nxt == S_DONE);
      r_winner  <= w_winner_nxt;
      r_draw    <= w_draw_nxt;
      r_win_row <= w_win_row_nxt;
      r_win_col <= w_win_col_nxt;
      r_win_dir <= w_win_dir_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.winner  = r_winner;
  assign bus.draw    = r_draw;
  assign bus.win_row = r_win_row;
  assign bus.win_col = r_win_col;
  assign bus.win_dir = r_win_dir;
endmodule

// File: tb/tb_c4_win_scanner.sv
// Directed and random scans of c4_win_scanner; expected results queue up when a scan is
// launched and are compared when done pulses.
module tb_c4_win_scanner;
  typedef logic [0:5][0:6][1:0] board_t;
  typedef struct {
    logic [1:0] winner;
    logic       draw;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  c4_win_scanner_if bus();
  c4_win_scanner dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] result_bits();
    return {bus.winner, bus.draw, bus.win_row, bus.win_col, bus.win_dir};
  endfunction

  function automatic logic [10:0] exp_bits(input exp_t e);
    return {e.winner, e.draw, e.row, e.col, e.dir};
  endfunction

  // Straightforward reference: walk anchors, try each direction in priority order.
  function automatic exp_t ref_scan(input board_t b);
    exp_t e;
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    bit full = 1'b1;
    for (int idx = 0; idx < 42; idx++) begin
      int r = idx / 7;
      int c = idx % 7;
      logic [1:0] a = b[r][c];
      if (a == 2'b01 || a == 2'b10) begin
        for (int d = 0; d < 4; d++) begin
          int er = r + 3 * dr[d];
          int ec = c + 3 * dc[d];
          if (er <= 5 && ec >= 0 && ec <= 6) begin
            bit ok = 1'b1;
            for (int k = 1; k < 4; k++)
              if (b[r + k * dr[d]][c + k * dc[d]] != a) ok = 1'b0;
            if (ok) begin
              e.winner = a; e.draw = 1'b0;
              e.row = 3'(r); e.col = 3'(c); e.dir = 2'(d);
              e.cyc = idx + 2;
              return e;
            end
          end
        end
      end
    end
    for (int c = 0; c < 7; c++)
      if (!(b[0][c] == 2'b01 || b[0][c] == 2'b10)) full = 1'b0;
    e.winner = 2'b00; e.draw = full; e.row = '0; e.col = '0; e.dir = '0; e.cyc = 43;
    return e;
  endfunction

  function automatic exp_t mk(input logic [1:0] w, input logic d, input int r, input int c,
                              input logic [1:0] dir, input int cyc);
    exp_t e;
    e.winner = w; e.draw = d; e.row = 3'(r); e.col = 3'(c); e.dir = dir; e.cyc = cyc;
    return e;
  endfunction

  // Launch a scan; optionally re-pulse start (with a new board) or assert rst mid-scan.
  task automatic run(input string tag, input board_t b, input int restart_at, input int rst_at);
    int   n;
    exp_t e;
    bit   seen;
    @(negedge clk);
    bus.board = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
    while (!bus.done && n < 60) begin
      if (n == restart_at) begin
        bus.start = 1'b1;
        bus.board = '0;
      end
      if (n == rst_at) rst = 1'b1;
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        check({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_rst_done"}, 32'(bus.done), 32'd0);
        check({tag, "_rst_result"}, 32'(result_bits()), 32'd0);
        seen = 1'b0;
        repeat (50) begin
          @(negedge clk);
          if (bus.done || bus.busy) seen = 1'b1;
        end
        check({tag, "_rst_quiet"}, 32'(seen), 32'd0);
        return;
      end
    end
    e = sb.pop_front();
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_cycle"}, 32'(n), 32'(e.cyc));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_result"}, 32'(result_bits()), 32'(exp_bits(e)));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"}, 32'(result_bits()), 32'(exp_bits(e)));
  endtask

  initial begin
    board_t b_empty, b_h, b_v, b_hv, b_dl, b_dr, b_draw, b_rand;
    exp_t   e;
    bus.start = 1'b0;
    bus.board = '0;
    b_empty = '0;

    b_h = '0;
    for (int c = 0; c < 4; c++) b_h[5][c] = 2'b01;
    b_v = b_h;
    for (int r = 2; r < 6; r++) b_v[r][6] = 2'b10;
    b_hv = '0;
    for (int k = 0; k < 4; k++) begin b_hv[0][k] = 2'b01; b_hv[k][0] = 2'b01; end
    b_dl = '0;
    for (int k = 0; k < 4; k++) b_dl[2 + k][3 - k] = 2'b01;
    b_dr = '0;
    for (int k = 0; k < 4; k++) b_dr[2 + k][k] = 2'b10;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        b_draw[r][c] = ((r == 2 || r == 3) ^ (c % 2 == 1)) ? 2'b10 : 2'b01;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(result_bits()), 32'd0);

    sb.push_back(mk(2'b00, 1'b0, 0, 0, 2'b00, 43)); run("empty", b_empty, -1, -1);
    sb.push_back(mk(2'b01, 1'b0, 5, 0, 2'b00, 37)); run("p1_h", b_h, -1, -1);
    sb.push_back(mk(2'b10, 1'b0, 2, 6, 2'b01, 22)); run("p2_v", b_v, -1, -1);
    sb.push_back(mk(2'b01, 1'b0, 0, 0, 2'b00, 2));  run("h_over_v", b_hv, -1, -1);
    sb.push_back(mk(2'b01, 1'b0, 2, 3, 2'b11, 19)); run("p1_dl", b_dl, -1, -1);
    sb.push_back(mk(2'b10, 1'b0, 2, 0, 2'b10, 16)); run("p2_dr", b_dr, -1, -1);
    sb.push_back(mk(2'b00, 1'b1, 0, 0, 2'b00, 43)); run("draw", b_draw, -1, -1);

    sb.push_back(mk(2'b01, 1'b0, 5, 0, 2'b00, 37)); run("restart_ign", b_h, 5, -1);
    run("mid_rst", b_h, -1, 10);
    sb.push_back(mk(2'b10, 1'b0, 2, 0, 2'b10, 16)); run("after_rst", b_dr, -1, -1);

    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++)
          b_rand[r][c] = (r < t % 4) ? 2'b00 : 2'($urandom_range(0, 3));
      e = ref_scan(b_rand);
      sb.push_back(e);
      run("random", b_rand, -1, -1);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/c4_win_scanner.md
# c4_win_scanner

- Reads the 6x7 Connect 4 board matrix produced by the board insertion logic and decides whether the game has ended: win for player 1 or 2, draw, or no result.
- A start pulse takes a snapshot of the board. The block then scans one anchor cell per cycle and pulses done with the result.
- Sits between the board storage and the game controller. The controller issues start after every insertion and waits for done before enabling the next move.

## Interface

Parameters:
- none. Geometry is fixed at 6 rows x 7 columns with a win length of 4. Cell encoding is 00 empty, 01 player 1, 10 player 2, 11 invalid (treated as empty).

Ports:
- clk  in  1  system clock; one clock domain; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a scan; sampled only in IDLE.
- board  in  2 per cell, [0:5][0:6]  board matrix; row 0 is the top row, row 5 the bottom row.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse when a result is available.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- draw  out  1  board full with no win.
- win_row  out  3  row of the winning anchor cell.
- win_col  out  3  column of the winning anchor cell.
- win_dir  out  2  line direction from the anchor: 00 horizontal (+col), 01 vertical (+row), 10 diagonal down-right (+row,+col), 11 diagonal down-left (+row,−col).

## Operation

FSM states: IDLE, SCAN, DONE.

**IDLE**
- start=1: copy board into an internal 84-bit snapshot, set idx=0, clear winner/draw/win_row/win_col/win_dir, go to SCAN.
- start=0: hold all outputs.

**SCAN**
- Evaluates anchor (r,c) with r=idx/7 and c=idx%7, over idx 0..41 in row-major order (top-left first).
- The anchor matches only if it is 01 or 10.
- Direction validity and required equal cells (anchor plus the three listed):
  - H: valid if c≤3; cells (r,c+1..c+3).
  - V: valid if r≤2; cells (r+1..r+3,c).
  - DR: valid if r≤2 and c≤3; cells (r+k,c+k).
  - DL: valid if r≤2 and c≥3; cells (r+k,c−k).
- Priority when several directions match at the same anchor: H > V > DR > DL.
- The first matching anchor in scan order wins. On a match: latch winner=anchor value, win_row=r, win_col=c, win_dir; go to DONE.
- No match and idx=41: draw=1 if all seven row-0 cells of the snapshot are non-empty, else draw=0 and winner=00; go to DONE.
- Otherwise idx increments by 1.
- The scan reads only the snapshot, so board may change during SCAN without effect.

**DONE**
- done=1 for exactly one cycle, then go to IDLE.
- start is ignored here.

**Hold and boundary rules**
- Result outputs hold from DONE until the next start is accepted in IDLE.
- start while in SCAN or DONE is ignored; it is neither queued nor restarts the scan.
- rst in any state, including mid-SCAN: next state IDLE, idx=0, and all outputs reset.
- Row 0 full is the draw criterion. Gravity guarantees that a full top row means a full board.

## Timing

- Reset values: busy=0, done=0, winner=00, draw=0, win_row=0, win_col=0, win_dir=00; state IDLE; snapshot cleared.
- Let the cycle in which start is sampled in IDLE be cycle 0.
  - Cycle 1: SCAN with idx=0, busy=1.
  - Cycle k+1: anchor index k is evaluated.
- Win at anchor k: done=1 in cycle k+2, with busy=0 in that cycle.
- No win: done=1 in cycle 43. Worst-case latency is 43 cycles.
- Earliest next start is accepted in cycle k+3 (the first IDLE cycle).
- All outputs are registered; no combinational path from start or board to any output.

## Test plan

- Empty board, start pulse → busy cycles 1–42; done in cycle 43 with winner=00, draw=0.
- Player 1 at row 5, cols 0–3 → anchor idx 35; done cycle 37; winner=01, win_row=5, win_col=0, win_dir=00.
- Player 2 at col 6, rows 2–5, plus player 1 at row 5, cols 0–3 → first hit idx 20; done cycle 22; winner=10, win_row=2, win_col=6, win_dir=01. Separate check: an anchor matching both H and V reports win_dir=00.
- Player 1 at (2,3),(3,2),(4,1),(5,0) → idx 17; done cycle 19; win_dir=11. Player 2 at (2,0),(3,1),(4,2),(5,3) → idx 14; done cycle 16; win_dir=10.
- Full no-win board, rows 0,1,4,5 = 1212121 and rows 2,3 = 2121212 (1=01, 2=10) → done cycle 43; draw=1, winner=00.
- Robustness sequence:
  - start again in cycle 5 of a scan: ignored, done still at the original cycle.
  - change board during SCAN: result unchanged.
  - assert rst in cycle 10: next cycle IDLE, busy=0, and no done pulse.
  - a subsequent start then scans normally.
